// File: rtl/histeq_seq_ctrl.sv
// Sequencer for histogram equalization: CLEAR -> HIST -> HDRAIN -> CDF -> MAP -> MDRAIN -> DONE.
// Latency: run length 256 + 2N + 2*RD_LAT + MAP_LAT + CDF_WAIT + 1 cycles after start is accepted.
// Backpressure: none; memories must accept one request per cycle. Abort flushes everything to IDLE.
module histeq_seq_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int MAP_LAT  = 0,
  parameter int CDF_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] num_words,
  output logic              busy,
  output logic              done,
  output logic [2:0]        phase,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              hist_clr,
  output logic [7:0]        hist_clr_addr,
  output logic              hist_en,
  output logic              ac_we,
  output logic              map_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  // Counter must hold both a word index and the 0..255 bin index.
  localparam int CNT_W = (ADDR_W > 8) ? ADDR_W : 8;
  // Total delay from a read request to its write-back.
  localparam int PD    = RD_LAT + MAP_LAT;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_HIST   = 3'd2,
    S_HDRAIN = 3'd3,
    S_CDF    = 3'd4,
    S_MAP    = 3'd5,
    S_MDRAIN = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, last_cnt;
  logic [ADDR_W-1:0] n_q, n_d;
  logic              cnt_last;

  // Read-request delay line: valid, "came from MAP" tag, and address.
  logic [PD-1:0]     pv_q, pm_q;
  logic [ADDR_W-1:0] pa_q [PD];

  // State, phase counter and latched word count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
    end
  end

  // Next-state: each phase ends when the counter reaches its last index, which
  // keeps N = 2^ADDR_W-1 safe since we compare against N-1 instead of N.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    n_d      = n_q;
    last_cnt = '0;
    case (state_q)
      S_CLEAR:      last_cnt = CNT_W'(255);
      S_HIST,
      S_MAP:        last_cnt = CNT_W'(n_q - ADDR_W'(1));
      S_HDRAIN:     last_cnt = CNT_W'(RD_LAT - 1);
      S_CDF:        last_cnt = CNT_W'(CDF_WAIT - 1);
      S_MDRAIN:     last_cnt = CNT_W'(PD - 1);
      default:      last_cnt = '0;
    endcase
    cnt_last = (cnt_q == last_cnt);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          if (num_words != '0) begin
            n_d     = num_words;
            state_d = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_CLEAR:  if (cnt_last) begin state_d = S_HIST;   cnt_d = '0; end
      S_HIST:   if (cnt_last) begin state_d = S_HDRAIN; cnt_d = '0; end
      S_HDRAIN: if (cnt_last) begin state_d = S_CDF;    cnt_d = '0; end
      S_CDF:    if (cnt_last) begin state_d = S_MAP;    cnt_d = '0; end
      S_MAP:    if (cnt_last) begin state_d = S_MDRAIN; cnt_d = '0; end
      S_MDRAIN: if (cnt_last) begin state_d = S_DONE;   cnt_d = '0; end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Delay line tracking reads through memory latency and the lookup stage; abort empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      pm_q <= '0;
      for (int i = 0; i < PD; i++) pa_q[i] <= '0;
    end else if (abort) begin
      pv_q <= '0;
      pm_q <= '0;
    end else begin
      pv_q[0] <= rd_en;
      pm_q[0] <= (state_q == S_MAP);
      pa_q[0] <= rd_addr;
      for (int i = 1; i < PD; i++) begin
        pv_q[i] <= pv_q[i-1];
        pm_q[i] <= pm_q[i-1];
        pa_q[i] <= pa_q[i-1];
      end
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign phase         = state_q;
  assign rd_en         = (state_q == S_HIST) || (state_q == S_MAP);
  assign rd_addr       = rd_en ? cnt_q[ADDR_W-1:0] : '0;
  assign hist_clr      = (state_q == S_CLEAR);
  assign hist_clr_addr = hist_clr ? cnt_q[7:0] : '0;
  assign ac_we         = (state_q == S_CDF) && (cnt_q == CNT_W'(CDF_WAIT - 1));
  // Taps: RD_LAT for read data valid, RD_LAT+MAP_LAT for the remapped word.
  assign hist_en       = pv_q[RD_LAT-1] & ~pm_q[RD_LAT-1];
  assign map_en        = pv_q[RD_LAT-1] &  pm_q[RD_LAT-1];
  assign wr_en         = pv_q[PD-1] & pm_q[PD-1];
  assign wr_addr       = pa_q[PD-1];

endmodule

// File: tb/tb_histeq_seq_ctrl.sv
// Bench for histeq_seq_ctrl: two instances (default parameters, and ADDR_W=4/RD_LAT=3/MAP_LAT=2)
// share one stimulus stream; a timeline model predicts every output per cycle into per-instance queues
// and a negedge monitor pops and compares.
module tb_histeq_seq_ctrl;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [2:0]  phase;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic        hist_clr;
    logic [7:0]  clr_addr;
    logic        hist_en;
    logic        ac_we;
    logic        map_en;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic        full;   // compare addresses even when their enable is low (reset state)
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort;
  logic [15:0] nw;

  logic        busy0, done0, rd_en0, hist_clr0, hist_en0, ac_we0, map_en0, wr_en0;
  logic [2:0]  phase0;
  logic [15:0] rd_addr0, wr_addr0;
  logic [7:0]  clr_addr0;

  logic        busy1, done1, rd_en1, hist_clr1, hist_en1, ac_we1, map_en1, wr_en1;
  logic [2:0]  phase1;
  logic [3:0]  rd_addr1, wr_addr1;
  logic [7:0]  clr_addr1;

  histeq_seq_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_words(nw),
    .busy(busy0), .done(done0), .phase(phase0), .rd_en(rd_en0), .rd_addr(rd_addr0),
    .hist_clr(hist_clr0), .hist_clr_addr(clr_addr0), .hist_en(hist_en0), .ac_we(ac_we0),
    .map_en(map_en0), .wr_en(wr_en0), .wr_addr(wr_addr0)
  );

  histeq_seq_ctrl #(.ADDR_W(4), .RD_LAT(3), .MAP_LAT(2), .CDF_WAIT(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_words(nw[3:0]),
    .busy(busy1), .done(done1), .phase(phase1), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .hist_clr(hist_clr1), .hist_clr_addr(clr_addr1), .hist_en(hist_en1), .ac_we(ac_we1),
    .map_en(map_en1), .wr_en(wr_en1), .wr_addr(wr_addr1)
  );

  int   tests = 0;
  int   fails = 0;
  obs_t q0[$];
  obs_t q1[$];
  bit   act [2];
  int   off [2];
  int   nm  [2];
  int   done_exp [2];
  int   done_seen [2];

  function automatic int rl_of(int id); return (id != 0) ? 3 : 1; endfunction
  function automatic int ml_of(int id); return (id != 0) ? 2 : 0; endfunction

  // Run length in cycles from acceptance to the done cycle inclusive.
  function automatic int run_len(int id, int n);
    if (n == 0) return 1;
    return 256 + 2 * n + 2 * rl_of(id) + ml_of(id) + 2 + 1;
  endfunction

  // Expected outputs at cycle oc (1 = first cycle after start was accepted).
  function automatic obs_t expect_at(int id, bit a, int oc, int n);
    obs_t e;
    int rl, ml, cw, mask, hs, he, m0, me, t, k;
    e    = '0;
    rl   = rl_of(id);
    ml   = ml_of(id);
    cw   = 2;
    mask = (id != 0) ? 'hF : 'hFFFF;
    if (!a) return e;
    e.busy = 1'b1;
    if (n == 0) begin
      e.done  = 1'b1;
      e.phase = 3'd7;
      return e;
    end
    hs = 257;
    he = 256 + n;
    m0 = 257 + n + rl + cw;
    me = m0 + n - 1;
    t  = run_len(id, n);
    if      (oc <= 256)          e.phase = 3'd1;
    else if (oc <= he)           e.phase = 3'd2;
    else if (oc <= he + rl)      e.phase = 3'd3;
    else if (oc <= he + rl + cw) e.phase = 3'd4;
    else if (oc <= me)           e.phase = 3'd5;
    else if (oc <  t)            e.phase = 3'd6;
    else                         e.phase = 3'd7;
    if (oc <= 256) begin e.hist_clr = 1'b1; e.clr_addr = 8'(oc - 1); end
    if (oc >= hs && oc <= he) begin e.rd_en = 1'b1; e.rd_addr = 16'((oc - hs) & mask); end
    if (oc >= m0 && oc <= me) begin e.rd_en = 1'b1; e.rd_addr = 16'((oc - m0) & mask); end
    k = oc - rl;
    if (k >= hs && k <= he) e.hist_en = 1'b1;
    if (k >= m0 && k <= me) e.map_en  = 1'b1;
    k = oc - rl - ml;
    if (k >= m0 && k <= me) begin e.wr_en = 1'b1; e.wr_addr = 16'((k - m0) & mask); end
    e.ac_we = (oc == he + rl + cw);
    e.done  = (oc == t);
    return e;
  endfunction

  // Advance one instance's model across a clock edge and queue its expected outputs.
  task automatic model_edge(int id, bit s, bit ab, int nval);
    obs_t e;
    if (!rst_n || ab) begin
      act[id] = 1'b0;
    end else if (!act[id]) begin
      if (s) begin act[id] = 1'b1; off[id] = 1; nm[id] = nval; end
    end else if (off[id] == run_len(id, nm[id])) begin
      act[id] = 1'b0;
    end else begin
      off[id] = off[id] + 1;
    end
    e      = expect_at(id, act[id], off[id], nm[id]);
    e.full = !rst_n;
    if (e.done) done_exp[id] = done_exp[id] + 1;
    if (id == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic step(bit s, bit ab, logic [15:0] v);
    start = s;
    abort = ab;
    nw    = v;
    model_edge(0, s, ab, int'(v));
    model_edge(1, s, ab, int'(v[3:0]));
    @(posedge clk);
    #1;
  endtask

  // Drop reset in the middle of a cycle: the current cycle must already read all-zero.
  task automatic reset_mid();
    obs_t z;
    z      = '0;
    z.full = 1'b1;
    rst_n  = 1'b0;
    void'(q0.pop_back());
    void'(q1.pop_back());
    q0.push_back(z);
    q1.push_back(z);
    act[0] = 1'b0;
    act[1] = 1'b0;
  endtask

  task automatic check(string name, obs_t a, obs_t e);
    tests = tests + 1;
    a.full = e.full;
    if (!e.full) begin
      if (!e.rd_en)    begin a.rd_addr  = '0; e.rd_addr  = '0; end
      if (!e.hist_clr) begin a.clr_addr = '0; e.clr_addr = '0; end
      if (!e.wr_en)    begin a.wr_addr  = '0; e.wr_addr  = '0; end
    end
    if (a !== e) begin
      fails = fails + 1;
      $display("FAIL %s t=%0t got ph=%0d busy=%b done=%b rd=%b/%h clr=%b/%h hen=%b acwe=%b men=%b wr=%b/%h, required ph=%0d busy=%b done=%b rd=%b/%h clr=%b/%h hen=%b acwe=%b men=%b wr=%b/%h",
               name, $time, a.phase, a.busy, a.done, a.rd_en, a.rd_addr, a.hist_clr, a.clr_addr,
               a.hist_en, a.ac_we, a.map_en, a.wr_en, a.wr_addr,
               e.phase, e.busy, e.done, e.rd_en, e.rd_addr, e.hist_clr, e.clr_addr,
               e.hist_en, e.ac_we, e.map_en, e.wr_en, e.wr_addr);
    end
  endtask

  // Monitor: compare whatever the instances present against the oldest queued prediction.
  always @(negedge clk) begin
    obs_t a, e;
    if (done0) done_seen[0] = done_seen[0] + 1;
    if (done1) done_seen[1] = done_seen[1] + 1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = '{busy0, done0, phase0, rd_en0, rd_addr0, hist_clr0, clr_addr0,
            hist_en0, ac_we0, map_en0, wr_en0, wr_addr0, 1'b0};
      check("dut0_cycle", a, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = '{busy1, done1, phase1, rd_en1, {12'd0, rd_addr1}, hist_clr1, clr_addr1,
            hist_en1, ac_we1, map_en1, wr_en1, {12'd0, wr_addr1}, 1'b0};
      check("dut1_cycle", a, e);
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    nw    = '0;
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; off[i] = 0; nm[i] = 0; done_exp[i] = 0; done_seen[i] = 0;
    end

    // Reset state, then release.
    repeat (3) step(1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;
    repeat (2) step(1'b0, 1'b0, 16'd0);

    // N=4 full run on both instances.
    step(1'b1, 1'b0, 16'd4);
    repeat (290) step(1'b0, 1'b0, 16'd0);

    // Reset asserted mid-CLEAR, start ignored while in reset, idle after release.
    step(1'b1, 1'b0, 16'd4);
    repeat (99) step(1'b0, 1'b0, 16'd0);
    reset_mid();
    repeat (2) step(1'b1, 1'b0, 16'd4);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 16'd0);

    // num_words = 0: immediate done, nothing else.
    step(1'b1, 1'b0, 16'd0);
    repeat (4) step(1'b0, 1'b0, 16'd0);

    // N=8, abort in MAP while the default instance presents rd_addr=2, then a clean rerun.
    step(1'b1, 1'b0, 16'd8);
    repeat (269) step(1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b1, 16'd0);
    repeat (5) step(1'b0, 1'b0, 16'd0);
    step(1'b1, 1'b0, 16'd8);
    repeat (300) step(1'b0, 1'b0, 16'd0);

    // start held high through several N=1 runs; start while busy must not relaunch.
    repeat (700) step(1'b1, 1'b0, 16'd1);
    repeat (300) step(1'b0, 1'b0, 16'd0);

    // N=5 (the delayed instance exercises RD_LAT=3, MAP_LAT=2).
    step(1'b1, 1'b0, 16'd5);
    repeat (300) step(1'b0, 1'b0, 16'd0);

    // Largest legal count for the 4-bit instance.
    step(1'b1, 1'b0, 16'd15);
    repeat (330) step(1'b0, 1'b0, 16'd0);

    // abort together with start in IDLE: stay idle.
    step(1'b1, 1'b1, 16'd3);
    repeat (3) step(1'b0, 1'b0, 16'd0);

    // Random starts, counts and occasional aborts.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      bit s, ab;
      s  = ($urandom_range(0, 7) == 0);
      ab = ($urandom_range(0, 399) == 0);
      v  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(1, 24));
      step(s, ab, v);
    end
    repeat (400) step(1'b0, 1'b0, 16'd0);

    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      tests = tests + 1;
      if (done_seen[i] != done_exp[i]) begin
        fails = fails + 1;
        $display("FAIL done_count dut%0d got %0d required %0d", i, done_seen[i], done_exp[i]);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
